// File: rtl/spi_rx_pkg.sv
// Shared constants and types for the SPI receive path and its transmitter peer.
package spi_rx_pkg;

  localparam int CLK_FREQ        = 100_000_000;
  localparam int SCL_FREQ        = 15_000_000;
  localparam int SPI_WIDTH       = 8;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop pin synchronizer followed by a history flop, producing the
// synchronized level plus single-cycle rise and fall pulses.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the raw pin through the synchronizer chain and keep one cycle of history
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_rx.sv
// Mode-0, MSB-first SPI slave receiver. Pins are oversampled by clk, each
// completed frame is presented with a one-cycle valid pulse, and a chip-select
// release in the middle of a frame produces a one-cycle frame_err pulse.
module spi_rx
  import spi_rx_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl,
  input  logic             sda,
  input  logic             cs,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic w_sclS;
  logic w_sclRise;
  logic w_sdaS;
  logic w_csS;
  logic w_csRise;
  logic w_csFall;

  spi_state_t r_state;
  spi_state_t w_nextState;
  logic       w_busy;

  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_bitCnt;
  logic [WIDTH-1:0] r_dataOut;
  logic             r_valid;
  logic             r_frameErr;
  logic [WIDTH-1:0] w_shifted;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_syncScl (
    .clk     (clk),
    .reset   (reset),
    .i_pin   (scl),
    .o_level (w_sclS),
    .o_rise  (w_sclRise),
    .o_fall  ()
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_syncSda (
    .clk     (clk),
    .reset   (reset),
    .i_pin   (sda),
    .o_level (w_sdaS),
    .o_rise  (),
    .o_fall  ()
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_syncCs (
    .clk     (clk),
    .reset   (reset),
    .i_pin   (cs),
    .o_level (w_csS),
    .o_rise  (w_csRise),
    .o_fall  (w_csFall)
  );

  assign w_shifted = {r_shreg[WIDTH-2:0], w_sdaS};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: a select opens a frame window, a deselect closes it
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_csFall) w_nextState = SHIFT;
      SHIFT:   if (w_csRise) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // FSM outputs: busy marks an open frame window
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      SHIFT:   w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // Shifter, bit counter and the valid/frame_err pulses; a cs release wins
  // over a coincident scl edge, which is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg    <= '0;
      r_bitCnt   <= '0;
      r_dataOut  <= '0;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      if (r_state == IDLE) begin
        if (w_csFall) begin
          r_shreg  <= '0;
          r_bitCnt <= '0;
        end
      end else begin
        if (w_csRise) begin
          r_frameErr <= (r_bitCnt != '0);
          r_shreg    <= '0;
          r_bitCnt   <= '0;
        end else if (w_sclRise && !w_csS) begin
          r_shreg <= w_shifted;
          if (r_bitCnt == LAST_BIT) begin
            r_dataOut <= w_shifted;
            r_valid   <= 1'b1;
            r_bitCnt  <= '0;
          end else begin
            r_bitCnt <= r_bitCnt + 1'b1;
          end
        end
      end
    end
  end

  assign data_out  = r_dataOut;
  assign valid     = r_valid;
  assign busy      = w_busy;
  assign frame_err = r_frameErr;

  // Synchronized scl level is only consumed through its rise pulse
  logic w_unusedScl;
  assign w_unusedScl = w_sclS;

endmodule

// File: tb/tb_spi_rx.sv
// Directed testbench for spi_rx: a 15 MHz mode-0 master model drives the
// pins against a 100 MHz system clock.
module tb_spi_rx;

  logic       clk;
  logic       reset;
  logic       scl;
  logic       sda;
  logic       cs;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;
  logic       frame_err;

  int checks;
  int errors;

  int         validCount;
  int         errCount;
  int         bothHigh;
  int         longValid;
  int         longErr;
  logic       prevValid;
  logic       prevErr;
  logic [7:0] rxQ[$];

  spi_rx dut (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .cs        (cs),
    .data_out  (data_out),
    .valid     (valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  // 100 MHz system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse monitor sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      if (valid) begin
        validCount++;
        rxQ.push_back(data_out);
      end
      if (frame_err) errCount++;
      if (valid && frame_err) bothHigh++;
      if (valid && prevValid) longValid++;
      if (frame_err && prevErr) longErr++;
    end
    prevValid = valid;
    prevErr   = frame_err;
  end

  task automatic waitClks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic csLow();
    cs = 1'b0;
    #60;
  endtask

  task automatic csHigh();
    #40;
    cs = 1'b1;
    waitClks(10);
  endtask

  // Mode 0: data set while scl is low, sampled on the rising edge
  task automatic spiBits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda = b[i];
      #33;
      scl = 1'b1;
      #33;
      scl = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    scl = 1'b0;
    sda = 1'b0;
    cs = 1'b1;
    waitClks(4);
    checks++;
    if (data_out !== 8'h00 || valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got data=%h valid=%b busy=%b ferr=%b required 00 0 0 0",
               data_out, valid, busy, frame_err);
    end
    reset = 1'b0;
    waitClks(4);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy got %b required 0", busy);
    end
  endtask

  task automatic test_single_byte();
    int v0, e0;
    v0 = validCount;
    e0 = errCount;
    rxQ.delete();
    csLow();
    spiBits(8'hA5, 8);
    csHigh();
    checks++;
    if (validCount - v0 !== 1) begin
      errors++;
      $display("FAIL single_valid_count got %0d required 1", validCount - v0);
    end
    checks++;
    if (data_out !== 8'hA5) begin
      errors++;
      $display("FAIL single_data got %h required a5", data_out);
    end
    checks++;
    if (errCount !== e0) begin
      errors++;
      $display("FAIL single_no_ferr got %0d required 0", errCount - e0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_end got %b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = validCount;
    rxQ.delete();
    csLow();
    spiBits(8'h3C, 8);
    waitClks(6);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL burst_busy_between got %b required 1", busy);
    end
    spiBits(8'hC3, 8);
    csHigh();
    checks++;
    if (validCount - v0 !== 2 || rxQ.size() !== 2) begin
      errors++;
      $display("FAIL burst_valid_count got %0d required 2", validCount - v0);
    end else begin
      checks++;
      if (rxQ[0] !== 8'h3C || rxQ[1] !== 8'hC3) begin
        errors++;
        $display("FAIL burst_order got %h %h required 3c c3", rxQ[0], rxQ[1]);
      end
    end
    checks++;
    if (data_out !== 8'hC3) begin
      errors++;
      $display("FAIL burst_last_data got %h required c3", data_out);
    end
  endtask

  task automatic test_truncated();
    int v0, e0;
    v0 = validCount;
    e0 = errCount;
    csLow();
    spiBits(8'hFF, 5);
    csHigh();
    checks++;
    if (errCount - e0 !== 1) begin
      errors++;
      $display("FAIL trunc_ferr_count got %0d required 1", errCount - e0);
    end
    checks++;
    if (validCount !== v0) begin
      errors++;
      $display("FAIL trunc_no_valid got %0d required 0", validCount - v0);
    end
    checks++;
    if (data_out !== 8'hC3) begin
      errors++;
      $display("FAIL trunc_data_held got %h required c3", data_out);
    end
    csLow();
    spiBits(8'h81, 8);
    csHigh();
    checks++;
    if (validCount - v0 !== 1 || data_out !== 8'h81) begin
      errors++;
      $display("FAIL trunc_next_frame got count=%0d data=%h required 1 81", validCount - v0, data_out);
    end
    checks++;
    if (errCount - e0 !== 1) begin
      errors++;
      $display("FAIL trunc_ferr_after_full got %0d required 1", errCount - e0);
    end
  endtask

  task automatic test_noise_deselected();
    int v0, e0, busyHits;
    v0 = validCount;
    e0 = errCount;
    busyHits = 0;
    for (int i = 0; i < 20; i++) begin
      sda = 1'($urandom_range(0, 1));
      #33;
      scl = ~scl;
      #7;
      if (busy !== 1'b0) busyHits++;
    end
    scl = 1'b0;
    waitClks(8);
    checks++;
    if (validCount !== v0 || errCount !== e0) begin
      errors++;
      $display("FAIL noise_pulses got valid=%0d ferr=%0d required 0 0", validCount - v0, errCount - e0);
    end
    checks++;
    if (busyHits !== 0) begin
      errors++;
      $display("FAIL noise_busy got %0d busy samples required 0", busyHits);
    end
    checks++;
    if (data_out !== 8'h81) begin
      errors++;
      $display("FAIL noise_data_held got %h required 81", data_out);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    csLow();
    spiBits(8'hFF, 4);
    @(negedge clk);
    reset = 1'b1;
    waitClks(2);
    checks++;
    if (data_out !== 8'h00 || valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs got data=%h valid=%b busy=%b ferr=%b required 00 0 0 0",
               data_out, valid, busy, frame_err);
    end
    reset = 1'b0;
    v0 = validCount;
    e0 = errCount;
    waitClks(6);
    csHigh();
    csLow();
    spiBits(8'h5A, 8);
    csHigh();
    checks++;
    if (errCount !== e0) begin
      errors++;
      $display("FAIL midreset_no_ferr got %0d required 0", errCount - e0);
    end
    checks++;
    if (validCount - v0 !== 1 || data_out !== 8'h5A) begin
      errors++;
      $display("FAIL midreset_next_frame got count=%0d data=%h required 1 5a", validCount - v0, data_out);
    end
  endtask

  // Sends one frame and measures clk edges from the last scl rise to valid
  task automatic test_latency(input logic [7:0] b);
    int lat;
    logic seen;
    seen = 1'b0;
    lat = 0;
    csLow();
    spiBits(b, 7);
    sda = b[0];
    #33;
    scl = 1'b1;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        seen = 1'b1;
        lat = i;
      end
    end
    checks++;
    if (!seen || lat > 4) begin
      errors++;
      $display("FAIL latency_%h got %0d clk (seen=%b) required at most 4", b, lat, seen);
    end
    checks++;
    if (data_out !== b) begin
      errors++;
      $display("FAIL latency_data got %h required %h", data_out, b);
    end
    #20;
    scl = 1'b0;
    csHigh();
  endtask

  task automatic test_pulse_shape();
    checks++;
    if (bothHigh !== 0) begin
      errors++;
      $display("FAIL pulse_overlap got %0d cycles required 0", bothHigh);
    end
    checks++;
    if (longValid !== 0 || longErr !== 0) begin
      errors++;
      $display("FAIL pulse_width got valid=%0d ferr=%0d multi-cycle required 0 0", longValid, longErr);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    validCount = 0;
    errCount = 0;
    bothHigh = 0;
    longValid = 0;
    longErr = 0;
    prevValid = 1'b0;
    prevErr = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_truncated();
    test_noise_deselected();
    test_reset_mid_frame();
    test_latency(8'h5A);
    test_latency(8'h00);
    test_latency(8'hFF);
    test_pulse_shape();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so a stuck run still ends
  initial begin
    #2ms;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
